periph_clk_gen: RTL and testbench



---
 rtl/periph_clk_pkg.sv | 40 ++++
 rtl/periph_clk_gen_if.sv | 25 ++
 rtl/periph_clk_ch.sv | 69 ++++++
 rtl/periph_clk_gen.sv | 38 +++
 tb/tb_periph_clk_gen.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/periph_clk_pkg.sv
// Shared constants for the peripheral clock generator: counter width, reset
// divisors for the on-board peripherals and their channel indices.
package periph_clk_pkg;

   localparam int CNT_W_DEF = 16;
   localparam int unsigned SYS_CLK_HZ = 50_000_000;

   localparam int CH_I2C  = 0;
   localparam int CH_UART = 1;
   localparam int CH_LCD  = 2;

   typedef enum logic [1:0] {
      BAUD_9600,
      BAUD_19200,
      BAUD_115200
   } baud_e;

   // Divisor-minus-one that yields one tick every SYS_CLK_HZ/tick_hz clocks.
   function automatic logic [CNT_W_DEF-1:0] tick_div(input int unsigned tick_hz);
      return CNT_W_DEF'(SYS_CLK_HZ / tick_hz - 1);
   endfunction

   // I2C engine runs four ticks per SCL period; UART oversamples by 16.
   localparam logic [CNT_W_DEF-1:0] DIV_I2C_100K    = tick_div(4 * 100_000);
   localparam logic [CNT_W_DEF-1:0] DIV_UART_9600   = tick_div(16 * 9600);
   localparam logic [CNT_W_DEF-1:0] DIV_UART_19200  = tick_div(16 * 19200);
   localparam logic [CNT_W_DEF-1:0] DIV_UART_115200 = tick_div(16 * 115200);
   localparam logic [CNT_W_DEF-1:0] DIV_LCD         = tick_div(1_000_000);

   function automatic logic [CNT_W_DEF-1:0] uart_div(input baud_e baud);
      logic [CNT_W_DEF-1:0] div;
      unique case (baud)
         BAUD_19200:  div = DIV_UART_19200;
         BAUD_115200: div = DIV_UART_115200;
         default:     div = DIV_UART_9600;
      endcase
      return div;
   endfunction

endpackage

// File: rtl/periph_clk_gen_if.sv
// Core-side control and status bundle of the peripheral clock generator.
interface periph_clk_gen_if import periph_clk_pkg::*; #(
   parameter int NUM_CH = 3,
   parameter int CNT_W  = CNT_W_DEF
);

   logic [NUM_CH-1:0]       en;
   logic [NUM_CH*CNT_W-1:0] div_val;
   logic [NUM_CH-1:0]       div_load;
   logic                    align;
   logic [NUM_CH-1:0]       tick;
   logic [NUM_CH-1:0]       clk_out;
   logic [NUM_CH-1:0]       pend;

   modport master (
      output en, div_val, div_load, align,
      input  tick, clk_out, pend
   );

   modport slave (
      input  en, div_val, div_load, align,
      output tick, clk_out, pend
   );

endinterface

// File: rtl/periph_clk_ch.sv
// One divider channel: counter, active/pending divisor, registered tick and
// 50%-duty clock. Divisor changes take effect only at a period boundary.
module periph_clk_ch import periph_clk_pkg::*; #(
   parameter int               CNT_W   = CNT_W_DEF,
   parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [CNT_W-1:0] div_val,
   input  logic             div_load,
   input  logic             align,
   output logic             tick,
   output logic             clk_out,
   output logic             pend
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] act_div;
   logic [CNT_W-1:0] pend_div;
   logic             wrap;

   // Equality only: act_div never drops below cnt because it only changes when cnt restarts.
   assign wrap = en & (cnt == act_div);

   // NOTE: every register here is written with <= so all channel state updates from the same pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt      <= '0;
         act_div  <= DEF_DIV;
         pend_div <= '0;
         pend     <= 1'b0;
         tick     <= 1'b0;
         clk_out  <= 1'b0;
      end else if (align) begin
         cnt     <= '0;
         tick    <= 1'b0;
         clk_out <= 1'b0;
         pend    <= 1'b0;
         if (div_load)  act_div <= div_val;
         else if (pend) act_div <= pend_div;
      end else if (!en) begin
         // Idle channel has no period to protect, so a waiting divisor lands at once.
         cnt     <= '0;
         tick    <= 1'b0;
         clk_out <= 1'b0;
         pend    <= div_load;
         if (pend)     act_div  <= pend_div;
         if (div_load) pend_div <= div_val;
      end else if (wrap) begin
         cnt     <= '0;
         tick    <= 1'b1;
         clk_out <= ~clk_out;
         pend    <= 1'b0;
         if (div_load)  act_div <= div_val;
         else if (pend) act_div <= pend_div;
      end else begin
         cnt  <= cnt + CNT_W'(1);
         tick <= 1'b0;
         if (div_load) begin
            pend_div <= div_val;
            pend     <= 1'b1;
         end
      end
   end

   cnt_in_range: assert property (@(posedge clk) disable iff (reset) cnt <= act_div);

endmodule

// File: rtl/periph_clk_gen.sv
// Multi-channel peripheral clock generator: NUM_CH independent dividers that
// share only the global align strobe.
module periph_clk_gen import periph_clk_pkg::*; #(
   parameter int               NUM_CH  = 3,
   parameter int               CNT_W   = CNT_W_DEF,
   parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(1)
) (
   input logic              clk,
   input logic              reset,
   periph_clk_gen_if.slave  bus
);

   logic [NUM_CH-1:0] tick_v;
   logic [NUM_CH-1:0] clk_v;
   logic [NUM_CH-1:0] pend_v;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      periph_clk_ch #(
         .CNT_W   (CNT_W),
         .DEF_DIV (DEF_DIV)
      ) u_ch (
         .clk      (clk),
         .reset    (reset),
         .en       (bus.en[i]),
         .div_val  (bus.div_val[i*CNT_W +: CNT_W]),
         .div_load (bus.div_load[i]),
         .align    (bus.align),
         .tick     (tick_v[i]),
         .clk_out  (clk_v[i]),
         .pend     (pend_v[i])
      );
   end

   assign bus.tick    = tick_v;
   assign bus.clk_out = clk_v;
   assign bus.pend    = pend_v;

endmodule

// File: tb/tb_periph_clk_gen.sv
// Self-checking bench for periph_clk_gen: vector tables per scenario, expected
// outputs queued on drive and popped one edge later.
module tb_periph_clk_gen;
   import periph_clk_pkg::*;

   localparam int               NUM_CH  = 3;
   localparam int               CNT_W   = CNT_W_DEF;
   localparam int               DW      = NUM_CH * CNT_W;
   localparam logic [CNT_W-1:0] DEF_DIV = 16'd1;

   typedef logic [NUM_CH-1:0]   chv_t;
   typedef logic [3*NUM_CH-1:0] obs_t;

   typedef struct {
      chv_t          en;
      logic [DW-1:0] div_val;
      chv_t          div_load;
      logic          align;
      chv_t          tick;
      chv_t          clk_out;
      chv_t          pend;
   } vec_t;

   typedef struct {
      chv_t tick;
      chv_t clk_out;
      chv_t pend;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];
   exp_t sb[$];

   periph_clk_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

   periph_clk_gen #(
      .NUM_CH  (NUM_CH),
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input obs_t act, input obs_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got tick/clk/pend=%b, expected %b", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] dv(input int d2, input int d1, input int d0);
      return {CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
   endfunction

   function automatic void add(input chv_t en, input logic [DW-1:0] d, input chv_t ld,
                               input logic al, input chv_t t, input chv_t c, input chv_t p);
      vec_t v;
      v.en = en; v.div_val = d; v.div_load = ld; v.align = al;
      v.tick = t; v.clk_out = c; v.pend = p;
      vecs.push_back(v);
   endfunction

   task automatic drive(input chv_t en, input logic [DW-1:0] d, input chv_t ld, input logic al);
      bus.en       = en;
      bus.div_val  = d;
      bus.div_load = ld;
      bus.align    = al;
   endtask

   function automatic obs_t observe();
      return {bus.tick, bus.clk_out, bus.pend};
   endfunction

   // One configuration edge (no check); afterwards the bench sits just past that edge.
   task automatic setup(input chv_t en, input logic [DW-1:0] d, input chv_t ld, input logic al);
      drive(en, d, ld, al);
      @(posedge clk);
      #1;
      drive(en, d, '0, 1'b0);
   endtask

   task automatic do_reset();
      drive('0, '0, '0, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Row k of the table holds the inputs seen by edge k and the outputs expected after it.
   task automatic run_vecs(input string tag);
      exp_t e;
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].en, vecs[i].div_val, vecs[i].div_load, vecs[i].align);
         sb.push_back('{vecs[i].tick, vecs[i].clk_out, vecs[i].pend});
         @(posedge clk);
         #1;
         e = sb.pop_front();
         check($sformatf("%s[%0d]", tag, i + 1), observe(), {e.tick, e.clk_out, e.pend});
      end
      vecs.delete();
      bus.div_load = '0;
      bus.align    = 1'b0;
   endtask

   task automatic test_defaults();
      add(3'b111, '0, '0, 1'b0, 3'b000, 3'b000, 3'b000);
      add(3'b111, '0, '0, 1'b0, 3'b111, 3'b111, 3'b000);
      add(3'b111, '0, '0, 1'b0, 3'b000, 3'b111, 3'b000);
      add(3'b111, '0, '0, 1'b0, 3'b111, 3'b000, 3'b000);
      add(3'b111, '0, '0, 1'b0, 3'b000, 3'b000, 3'b000);
      add(3'b111, '0, '0, 1'b0, 3'b111, 3'b111, 3'b000);
      add(3'b111, '0, '0, 1'b0, 3'b000, 3'b111, 3'b000);
      add(3'b111, '0, '0, 1'b0, 3'b111, 3'b000, 3'b000);
      run_vecs("defaults");
   endtask

   // ch0 at period 10, new divisor 3 loaded mid-way through the second period.
   task automatic test_deferred();
      chv_t t, c, p;
      setup(3'b000, dv(0, 0, 9), 3'b001, 1'b1);
      for (int k = 1; k <= 28; k++) begin
         t = '0; c = '0; p = '0;
         t[0] = (k == 10) || (k == 20) || (k == 24) || (k == 28);
         c[0] = (k >= 10 && k < 20) || (k >= 24 && k < 28);
         p[0] = (k >= 15 && k < 20);
         add(3'b001, dv(0, 0, 3), (k == 15) ? 3'b001 : 3'b000, 1'b0, t, c, p);
      end
      run_vecs("deferred");
   endtask

   // ch1 at period 10: loads 5 then 7 before the wrap, then 2 exactly at a wrap.
   task automatic test_overwrite();
      chv_t t, c, p, ld;
      logic [DW-1:0] d;
      setup(3'b000, dv(0, 9, 0), 3'b010, 1'b1);
      for (int k = 1; k <= 32; k++) begin
         t = '0; c = '0; p = '0; ld = '0; d = dv(0, 0, 0);
         if (k == 2)  begin ld = 3'b010; d = dv(0, 5, 0); end
         if (k == 4)  begin ld = 3'b010; d = dv(0, 7, 0); end
         if (k == 26) begin ld = 3'b010; d = dv(0, 2, 0); end
         t[1] = (k == 10) || (k == 18) || (k == 26) || (k == 29) || (k == 32);
         c[1] = (k >= 10 && k < 18) || (k >= 26 && k < 29) || (k == 32);
         p[1] = (k >= 2 && k < 10);
         add(3'b010, d, ld, 1'b0, t, c, p);
      end
      run_vecs("overwrite");
   endtask

   // ch2 at period 4: disabled mid-period, loaded with 4 while idle, re-enabled.
   task automatic test_disable();
      chv_t t, c, p;
      setup(3'b000, dv(3, 0, 0), 3'b100, 1'b1);
      for (int k = 1; k <= 20; k++) begin
         t = '0; c = '0; p = '0;
         t[2] = (k == 4) || (k == 15) || (k == 20);
         c[2] = (k >= 4 && k < 6) || (k >= 15 && k < 20);
         p[2] = (k == 7);
         add((k >= 6 && k <= 10) ? 3'b000 : 3'b100, dv(4, 0, 0),
             (k == 7) ? 3'b100 : 3'b000, 1'b0, t, c, p);
      end
      run_vecs("disable");
   endtask

   // Periods 3/6/12 with ch2 switching to 9 through a pending load that align applies;
   // align lands in ch0's wrap cycle, then all ticks coincide 18 cycles later.
   task automatic test_align();
      chv_t t, c, p;
      int   per_pre[NUM_CH];
      int   per_post[NUM_CH];
      int   j;
      per_pre  = '{3, 6, 12};
      per_post = '{3, 6, 9};
      setup(3'b000, dv(11, 5, 2), 3'b111, 1'b1);
      for (int k = 1; k <= 24; k++) begin
         t = '0; c = '0; p = '0;
         for (int i = 0; i < NUM_CH; i++) begin
            if (k < 6) begin
               t[i] = (k % per_pre[i]) == 0;
               c[i] = ((k / per_pre[i]) % 2) == 1;
            end else if (k > 6) begin
               j = k - 6;
               t[i] = (j % per_post[i]) == 0;
               c[i] = ((j / per_post[i]) % 2) == 1;
            end
         end
         p[2] = (k >= 2 && k <= 5);
         add(3'b111, dv(8, 5, 2), (k == 2) ? 3'b100 : 3'b000, k == 6, t, c, p);
      end
      run_vecs("align");
   endtask

   // Reset lands between edges while ch0 has clk_out=1 and a load pending.
   task automatic test_async_reset();
      chv_t t, c, p;
      setup(3'b000, dv(0, 0, 9), 3'b001, 1'b1);
      for (int k = 1; k <= 11; k++) begin
         t = '0; c = '0; p = '0;
         t[0] = (k == 10);
         c[0] = (k >= 10);
         p[0] = (k == 11);
         add(3'b001, dv(0, 0, 3), (k == 11) ? 3'b001 : 3'b000, 1'b0, t, c, p);
      end
      run_vecs("pre_reset");
      reset = 1'b1;
      #1;
      check("async_reset_clear", observe(), '0);
      @(posedge clk);
      @(posedge clk);
      #1;
      drive(3'b001, dv(0, 0, 0), '0, 1'b0);
      reset = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         t = '0; c = '0;
         t[0] = (k % 2) == 0;
         c[0] = ((k / 2) % 2) == 1;
         add(3'b001, dv(0, 0, 0), '0, 1'b0, t, c, '0);
      end
      run_vecs("post_reset");
   endtask

   initial begin
      drive('0, '0, '0, 1'b0);
      #2;
      check("reset_state", observe(), '0);
      do_reset();
      check("after_release", observe(), '0);
      test_defaults();
      do_reset();
      test_deferred();
      do_reset();
      test_overwrite();
      do_reset();
      test_disable();
      do_reset();
      test_align();
      do_reset();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
